// File: rtl/frost32_irq_ctrl.sv
// Frost32 interrupt controller: edge-detected pending latch, enable mask,
// fixed lowest-index priority and single in-service tracking with EOI.
module frost32_irq_ctrl #(
  parameter int NUM_SRC = 8,
  parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src,
  input  logic               irq_ack,
  input  logic               reg_wr,
  input  logic               reg_rd,
  input  logic [1:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  output logic               interrupt,
  output logic               in_service
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ASSERT  = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_CAUSE   = 2'd2;

  localparam logic [1:0] ADDR_EOI     = 2'd3;

  logic [NUM_SRC-1:0] src_q_r;
  logic [NUM_SRC-1:0] enable_r;
  logic [NUM_SRC-1:0] pending_r;
  logic [IDX_W-1:0]   cause_idx_r;
  logic [1:0]         state_r;
  logic               interrupt_r;
  logic               in_service_r;
  logic [31:0]        rdata_r;

  logic [NUM_SRC-1:0] edge_s;
  logic [NUM_SRC-1:0] active_s;
  logic [NUM_SRC-1:0] w1c_mask_s;
  logic [NUM_SRC-1:0] clr_mask_s;
  logic [IDX_W-1:0]   winner_s;
  logic [1:0]         state_nxt_s;
  logic               capture_s;
  logic               eoi_s;
  logic [31:0]        rd_enable_s;
  logic [31:0]        rd_pending_s;
  logic [31:0]        rd_cause_s;
  logic               unused_s;

  assign edge_s     = src & ~src_q_r;
  assign active_s   = pending_r & enable_r;
  assign eoi_s      = reg_wr && (reg_addr == ADDR_EOI);
  assign w1c_mask_s = (reg_wr && (reg_addr == ADDR_PENDING)) ? reg_wdata[NUM_SRC-1:0]
                                                             : {NUM_SRC{1'b0}};
  // Upper write-data bits beyond NUM_SRC have no storage.
  assign unused_s   = ^reg_wdata;

  // Priority: downward scan so the lowest set index is written last.
  always_comb begin
    winner_s = {IDX_W{1'b0}};
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active_s[i]) winner_s = IDX_W'(i);
      else             winner_s = winner_s;
    end
  end

  // Next-state decode and capture qualification.
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (|active_s) state_nxt_s = ST_ASSERT;
        else           state_nxt_s = ST_IDLE;
      end
      ST_ASSERT: begin
        if (irq_ack) begin
          if (|active_s) begin
            state_nxt_s = ST_SERVICE;
            capture_s   = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else if (!(|active_s)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ASSERT;
        end
      end
      ST_SERVICE: begin
        if (eoi_s) state_nxt_s = ST_IDLE;
        else       state_nxt_s = ST_SERVICE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // One-hot clear of the captured source and zero-extended read views.
  always_comb begin
    clr_mask_s = {NUM_SRC{1'b0}};
    if (capture_s) clr_mask_s[winner_s] = 1'b1;
    else           clr_mask_s = {NUM_SRC{1'b0}};
    rd_enable_s                = {32{1'b0}};
    rd_enable_s[NUM_SRC-1:0]   = enable_r;
    rd_pending_s               = {32{1'b0}};
    rd_pending_s[NUM_SRC-1:0]  = pending_r;
    rd_cause_s                 = {32{1'b0}};
    rd_cause_s[31]             = in_service_r;
    rd_cause_s[IDX_W-1:0]      = cause_idx_r;
  end

  // Core state: edge history, enable, pending, FSM, capture and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q_r      <= src;
      enable_r     <= {NUM_SRC{1'b0}};
      pending_r    <= {NUM_SRC{1'b0}};
      cause_idx_r  <= {IDX_W{1'b0}};
      state_r      <= ST_IDLE;
      interrupt_r  <= 1'b0;
      in_service_r <= 1'b0;
    end else begin
      src_q_r      <= src;
      pending_r    <= (pending_r & ~w1c_mask_s & ~clr_mask_s) | edge_s;
      state_r      <= state_nxt_s;
      interrupt_r  <= (state_nxt_s == ST_ASSERT);
      in_service_r <= (state_nxt_s == ST_SERVICE);
      if (reg_wr && (reg_addr == ADDR_ENABLE)) enable_r <= reg_wdata[NUM_SRC-1:0];
      else                                     enable_r <= enable_r;
      if (capture_s) cause_idx_r <= winner_s;
      else           cause_idx_r <= cause_idx_r;
    end
  end

  // Register read port; data holds until the next read strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= {32{1'b0}};
    end else if (reg_rd) begin
      case (reg_addr)
        ADDR_ENABLE:  rdata_r <= rd_enable_s;
        ADDR_PENDING: rdata_r <= rd_pending_s;
        ADDR_CAUSE:   rdata_r <= rd_cause_s;
        default:      rdata_r <= {32{1'b0}};
      endcase
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign reg_rdata  = rdata_r;
  assign interrupt  = interrupt_r;
  assign in_service = in_service_r;

endmodule

// File: doc/frost32_irq_ctrl.md
# frost32_irq_ctrl

Interrupt controller sitting directly upstream of the Frost32 CPU's `interrupt` input. It edge-detects up to `NUM_SRC` peripheral interrupt lines, latches them as pending, applies an enable mask, and presents one level interrupt to the CPU. It also arbitrates by fixed priority and tracks a single in-service source until the handler signals end-of-interrupt through a small register port.

## Interface

Parameters:
- `NUM_SRC`, 8: number of interrupt sources, 1..32.
- `IDX_W`, `$clog2(NUM_SRC)` (min 1): width of the source index.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `src`  in  NUM_SRC  peripheral interrupt levels, synchronous to `clk`.
- `irq_ack`  in  1  one-cycle CPU pulse: interrupt taken.
- `reg_wr`  in  1  register write strobe.
- `reg_rd`  in  1  register read strobe.
- `reg_addr`  in  2  register select.
- `reg_wdata`  in  32  write data.
- `reg_rdata`  out  32  read data, registered.
- `interrupt`  out  1  level interrupt to the CPU.
- `in_service`  out  1  high while a captured source is being handled.

## Operation

- Registers:
  - 0 ENABLE: RW, bits [NUM_SRC-1:0].
  - 1 PENDING: R; a write clears every bit set in `reg_wdata` (W1C).
  - 2 CAUSE: R; bit31 = `in_service`, bits [IDX_W-1:0] = captured index, all other bits 0.
  - 3 EOI: W; any value ends service. Reads return 0.
- Edge detect: `src_q` is the previous sample of `src`. `edge = src & ~src_q`. During `rst`, `src_q` loads `src`, so a line already high at reset produces no edge.
- Pending update each cycle: `pending <= (pending & ~w1c_mask & ~capture_clear) | edge`. Set wins over W1C and over capture clear for the same bit.
- `active = pending & enable`.
- Winner: lowest set index of `active`.
- FSM, registered:
  - IDLE: `interrupt`=0. Go to ASSERT when `active != 0`.
  - ASSERT: `interrupt`=1.
    - On `irq_ack` with `active != 0`: capture the winner index into CAUSE, clear that pending bit, go to SERVICE.
    - On `irq_ack` with `active == 0`: go to IDLE, nothing captured.
    - If `active` drops to 0 without an ack (masked or W1C): return to IDLE.
  - SERVICE: `interrupt`=0, `in_service`=1. An EOI write goes to IDLE. `irq_ack` is ignored.
- EOI write outside SERVICE: ignored. `irq_ack` outside ASSERT: ignored.
- Simultaneous ENABLE write and `irq_ack`: capture uses the pre-write ENABLE value.
- Simultaneous EOI write and a new edge: go to IDLE. The pending bit still sets, and ASSERT follows.
- `reg_wr` and `reg_rd` in the same cycle on the same address: the read returns the pre-write value.
- Out-of-range bits: bits ≥ NUM_SRC read 0 and are ignored on write.

## Timing

- Reset values:
  - `interrupt`=0, `in_service`=0, `reg_rdata`=0.
  - ENABLE=0, PENDING=0, CAUSE index=0.
  - FSM=IDLE.
- Latency:
  - `src` first sampled high at posedge k: PENDING bit visible after k.
  - `interrupt` high after posedge k+1, if the source is enabled and the FSM is IDLE.
- Ack to capture: `irq_ack` at posedge m makes CAUSE valid and `interrupt` 0 after m.
- Read latency: `reg_rd` at posedge n puts data on `reg_rdata` after n. Data holds until the next read.
- EOI write at posedge n: IDLE after n. If any `active` bit remains, `interrupt` is high again after n+1.
- Reset mid-operation (any state): all state returns to reset values at the next posedge. Pending edges are lost.
- Level-held sources re-pend only after a fall and a new rise.

## Test plan

- **Basic flow** (reset, ENABLE=0x01, pulse `src[0]`):
  - PENDING=0x01 one cycle later; `interrupt`=1 one cycle after that.
  - `irq_ack` gives CAUSE=0x8000_0000, PENDING=0, `interrupt`=0.
  - EOI write gives `in_service`=0.
- **Priority** (ENABLE=0xFF, raise `src[5]` and `src[2]` in the same cycle, ack):
  - CAUSE=0x8000_0002, PENDING=0x20.
  - After EOI, `interrupt` reasserts one cycle later; second ack gives CAUSE=0x8000_0005.
- **Masking** (ENABLE=0x00, pulse `src[3]`):
  - PENDING=0x08, `interrupt` stays 0.
  - Write ENABLE=0x08: `interrupt`=1 one cycle later.
  - Write ENABLE=0 while in ASSERT: `interrupt` drops, FSM back to IDLE.
- **W1C vs set** (PENDING=0x04, write PENDING=0x04 in the same cycle as a new rise on `src[2]`):
  - PENDING stays 0x04.
  - W1C of 0x04 with no edge gives PENDING=0.
- **Reset with a level-high source** (assert `rst` with `src`=0x01 and FSM in SERVICE, then deassert):
  - All outputs 0, PENDING=0, no interrupt while `src[0]` stays high.
  - A fall then rise of `src[0]` pends normally.
- **Spurious and ignored strobes**:
  - `irq_ack` in IDLE: no state change.
  - EOI write in IDLE: no state change.
  - `irq_ack` in SERVICE: CAUSE unchanged.
